// File: rtl/mdu_pkg.sv
// mdu_pkg: MDUop codes, latencies and FSM state type shared by the MDU and its decoder.
package mdu_pkg;
    typedef enum logic [3:0] {
        OP_MULT  = 4'd0,
        OP_MULTU = 4'd1,
        OP_DIV   = 4'd2,
        OP_DIVU  = 4'd3,
        OP_MFHI  = 4'd4,
        OP_MFLO  = 4'd5,
        OP_MTHI  = 4'd6,
        OP_MTLO  = 4'd7,
        OP_NONE  = 4'd15
    } mdu_op_e;
    typedef enum logic {IDLE, BUSY} mdu_state_e;
    localparam logic [3:0] MULT_CYCLES = 4'd5;
    localparam logic [3:0] DIV_CYCLES  = 4'd10;
endpackage

// File: rtl/mdu_calc.sv
// mdu_calc: combinational HI/LO results for mult/multu/div/divu; wr=0 flags a divide by zero.
module mdu_calc
    import mdu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        wr
);
    logic [63:0] p_s, p_u;
    logic [31:0] q_s, r_s, q_u, r_u;
    assign p_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign p_u = {32'h0, a} * {32'h0, b};
    assign q_s = $signed(a) / $signed(b);
    assign r_s = $signed(a) % $signed(b);
    assign q_u = a / b;
    assign r_u = a % b;
    assign wr  = op[1] ? |b : 1'b1;
    always_comb begin
        hi = op == OP_MULT ? p_s[63:32] : op == OP_MULTU ? p_u[63:32] : op == OP_DIV ? r_s : r_u;
        lo = op == OP_MULT ? p_s[31:0]  : op == OP_MULTU ? p_u[31:0]  : op == OP_DIV ? q_s : q_u;
    end
endmodule

// File: rtl/mdu.sv
// mdu: multi-cycle multiply/divide unit with HI/LO registers; define MDU_FAST_EN for 1-cycle latency.
module mdu
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  MDUop,
    input  logic        Start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] MDUout
);
`ifdef MDU_FAST_EN
    localparam logic [3:0] MUL_LAT = 4'd1;
    localparam logic [3:0] DIV_LAT = 4'd1;
`else
    localparam logic [3:0] MUL_LAT = MULT_CYCLES;
    localparam logic [3:0] DIV_LAT = DIV_CYCLES;
`endif
    mdu_state_e  state;
    logic [3:0]  cnt;
    logic [31:0] hi, lo, tmp_hi, tmp_lo, c_hi, c_lo;
    logic        c_wr, go;

    mdu_calc u_calc (.op(MDUop), .a(A), .b(B), .hi(c_hi), .lo(c_lo), .wr(c_wr));

    assign go = Start && MDUop[3:2] == 2'b00;

    // Results park in tmp_* until the final busy edge so an abort never reaches HI/LO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            hi     <= 32'h0;
            lo     <= 32'h0;
            tmp_hi <= 32'h0;
            tmp_lo <= 32'h0;
        end else if (state == IDLE) begin
            if (go) begin
                tmp_hi <= c_wr ? c_hi : hi;
                tmp_lo <= c_wr ? c_lo : lo;
                cnt    <= (MDUop[1] ? DIV_LAT : MUL_LAT) - 4'd1;
                state  <= BUSY;
            end else if (MDUop == OP_MTHI) begin
                hi <= A;
            end else if (MDUop == OP_MTLO) begin
                lo <= A;
            end
        end else if (cnt == 4'd0) begin
            hi    <= tmp_hi;
            lo    <= tmp_lo;
            state <= IDLE;
        end else begin
            cnt <= cnt - 4'd1;
        end
    end

    assign Busy   = state == BUSY;
    assign MDUout = MDUop == OP_MFHI ? hi : MDUop == OP_MFLO ? lo : 32'h0;
endmodule
